// File: rtl/array_mult_pkg.sv
// Helper functions shared by the pipelined array multiplier and its stage slice.
// The stage payload struct depends on module parameters and lives in the top.
package array_mult_pkg;

  // Upper bound on 2*DATA_WIDTH supported by the constant helper below
  localparam int AMUL_MAX_W = 256;

  function automatic int amul_rows_per_stage(input int n, input int stages);
    return (stages > 0) ? n / stages : 1;
  endfunction

  // Baugh-Wooley correction constant 2^N + 2^(2N-1); callers keep the low 2N bits
  function automatic logic [AMUL_MAX_W-1:0] amul_bw_const(input int n);
    logic [AMUL_MAX_W-1:0] c;
    c          = '0;
    c[n]       = 1'b1;
    c[2*n-1]   = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/array_mult_stage.sv
// One combinational slice of the array multiplier: adds R consecutive
// partial-product rows (starting at first_row) to the incoming running sum.
// Build option: ARRAY_MULT_SIGNED_EN compiles in Baugh-Wooley correction;
// without it sgn is ignored and every row is a plain unsigned row.
module array_mult_stage
  import array_mult_pkg::*;
#(
  parameter int N     = 8,
  parameter int R     = 2,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             sgn,
  input  logic [2*N-1:0]   sum_in,
  input  logic [IDX_W-1:0] first_row,
  output logic [2*N-1:0]   sum_out
);

`ifdef ARRAY_MULT_SIGNED_EN
  localparam logic [AMUL_MAX_W-1:0] BW_FULL  = amul_bw_const(N);
  localparam logic [2*N-1:0]        BW_CONST = BW_FULL[2*N-1:0];
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
`endif

  logic [N-1:0]   pp;
  logic [2*N-1:0] acc;
  logic           b_bit;
  int             row;

  // accumulate this slice's rows; row i is (a & b[i]) << i
  always_comb begin
    acc   = sum_in;
    pp    = '0;
    b_bit = 1'b0;
    row   = 0;
    for (int r = 0; r < R; r++) begin
      row   = int'(first_row) + r;
      b_bit = |(b & ({{(N-1){1'b0}}, 1'b1} << row));
      pp    = a & {N{b_bit}};
`ifdef ARRAY_MULT_SIGNED_EN
      // sign-bit cross terms are inverted; the a[N-1]*b[N-1] term is not
      if (sgn) begin
        if (row == N-1) pp[N-2:0] = ~pp[N-2:0];
        else            pp[N-1]   = ~pp[N-1];
      end
`endif
      acc = acc + ({{N{1'b0}}, pp} << row);
    end
`ifdef ARRAY_MULT_SIGNED_EN
    // the correction constant enters once, in the slice that owns row 0
    if (sgn && first_row == '0) acc = acc + BW_CONST;
`endif
    sum_out = acc;
  end

endmodule

// File: rtl/pipelined_array_multiplier.sv
// Pipelined array multiplier with valid/ready on both sides and a sideband tag.
// STAGES register stages each hold one operand pair plus its running sum; all
// stages advance together and hold together under output backpressure.
// Build option: ARRAY_MULT_SIGNED_EN enables per-transaction signed mode
// (in_signed); without it the signed-flag bits are dropped and in_signed is ignored.
module pipelined_array_multiplier
  import array_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic                    in_signed,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_product,
  output logic [TAG_WIDTH-1:0]    out_tag
);

  localparam int N     = DATA_WIDTH;
  localparam int R     = amul_rows_per_stage(N, STAGES);
  localparam int IDX_W = $clog2(N);

  if (N < 2 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_param_err
    $error("pipelined_array_multiplier: need DATA_WIDTH>=2, 1<=STAGES<=DATA_WIDTH, DATA_WIDTH%%STAGES==0");
  end

  typedef struct packed {
    logic [N-1:0]         a;
    logic [N-1:0]         b;
`ifdef ARRAY_MULT_SIGNED_EN
    logic                 sgn;
`endif
    logic [TAG_WIDTH-1:0] tag;
    logic [2*N-1:0]       sum;
  } stage_t;

  logic                         adv;
  logic                         in_fire;
  logic [STAGES:1]              vld_pipe;
  logic [STAGES-1:0]            vld_src;
  stage_t                       st_in;
  stage_t [STAGES:1]            st_q;
  stage_t [STAGES-1:0]          st_src;
  logic [STAGES:1][2*N-1:0]     sum_nxt;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !rst;
  assign in_fire   = in_valid && in_ready;

  // payload entering stage 1; the running sum starts from zero
  always_comb begin
    st_in     = '0;
    st_in.a   = in_a;
    st_in.b   = in_b;
    st_in.tag = in_tag;
`ifdef ARRAY_MULT_SIGNED_EN
    st_in.sgn = in_signed;
`endif
  end

`ifndef ARRAY_MULT_SIGNED_EN
  logic unused_in_signed;
  assign unused_in_signed = in_signed;
`endif

  // predecessor of stage k is st_src[k-1]: the input for k=1, else stage k-1
  assign st_src[0]  = st_in;
  assign vld_src[0] = in_fire;
  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign st_src[k]  = st_q[k];
    assign vld_src[k] = vld_pipe[k];
  end

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    logic sgn;
`ifdef ARRAY_MULT_SIGNED_EN
    assign sgn = st_src[k-1].sgn;
`else
    assign sgn = 1'b0;
`endif
    array_mult_stage #(.N(N), .R(R), .IDX_W(IDX_W)) u_stage (
      .a         (st_src[k-1].a),
      .b         (st_src[k-1].b),
      .sgn       (sgn),
      .sum_in    (st_src[k-1].sum),
      .first_row (IDX_W'((k-1)*R)),
      .sum_out   (sum_nxt[k])
    );
  end

  // shift every stage (bubbles included) on advance, freeze all on a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      st_q     <= '0;
    end else if (adv) begin
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k]  <= vld_src[k-1];
        st_q[k]      <= st_src[k-1];
        st_q[k].sum  <= sum_nxt[k];
      end
    end
  end

  assign out_product = st_q[STAGES].sum;
  assign out_tag     = st_q[STAGES].tag;

  // operands of the last stage have no further consumer
  logic unused_tail;
  assign unused_tail = ^st_q[STAGES];

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Directed and random checks for pipelined_array_multiplier (N=8, STAGES=4).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_pipelined_array_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] out_product;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_array_multiplier #(.DATA_WIDTH(8), .STAGES(4), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag)
  );

  // back-to-back table: alternating signed flag, tags 0..7
  localparam logic [7:0]  B2B_A [8] = '{8'h03, 8'hFE, 8'h10, 8'h7F, 8'hAA, 8'h80, 8'h0C, 8'hFF};
  localparam logic [7:0]  B2B_B [8] = '{8'h05, 8'h03, 8'h10, 8'h81, 8'h02, 8'h7F, 8'h0D, 8'hFF};
`ifdef ARRAY_MULT_SIGNED_EN
  localparam logic [15:0] B2B_P [8] = '{16'h000F, 16'hFFFA, 16'h0100, 16'hC0FF,
                                        16'h0154, 16'hC080, 16'h009C, 16'h0001};
  localparam logic [15:0] SGN_FF01  = 16'hFFFF;
`else
  localparam logic [15:0] B2B_P [8] = '{16'h000F, 16'h02FA, 16'h0100, 16'h3FFF,
                                        16'h0154, 16'h3F80, 16'h009C, 16'hFE01};
  localparam logic [15:0] SGN_FF01  = 16'h00FF;
`endif

  // reference product for the random run, formed from integer arithmetic
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
`ifdef ARRAY_MULT_SIGNED_EN
    if (s) return $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
`endif
    return {8'h00, a} * {8'h00, b};
  endfunction

  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [3:0] t, input logic ordy);
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_signed = s; in_tag = t; out_ready = ordy;
    #1;
  endtask

  task automatic test_reset;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_product !== 16'h0) begin n_err++; $display("FAIL reset_product: got %h want 0000", out_product); end
    n_vec++; if (out_tag !== 4'h0) begin n_err++; $display("FAIL reset_tag: got %h want 0", out_tag); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    for (int c = 0; c < 7; c++) begin
      if (c == 0)      step(1, 8'hFF, 8'hFF, 0, 4'd3, 1);
      else if (c == 1) step(1, 8'h00, 8'hC8, 0, 4'd5, 1);
      else             step(0, 0, 0, 0, 0, 1);
      if (c < 2) begin
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL uns_in_ready c%0d: got %b want 1", c, in_ready); end
      end
      if (c == 3 || c == 6) begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL uns_idle c%0d: got valid %b want 0", c, out_valid); end
      end
      if (c == 4) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_product !== 16'hFE01 || out_tag !== 4'd3) begin
          n_err++; $display("FAIL uns_255x255: got v%b %h t%h want v1 fe01 t3", out_valid, out_product, out_tag);
        end
      end
      if (c == 5) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_product !== 16'h0000 || out_tag !== 4'd5) begin
          n_err++; $display("FAIL uns_0x200: got v%b %h t%h want v1 0000 t5", out_valid, out_product, out_tag);
        end
      end
    end
  endtask

  task automatic test_signed;
    logic [15:0] exp_p [4];
    exp_p[0] = 16'h4000; exp_p[1] = 16'h4000; exp_p[2] = SGN_FF01; exp_p[3] = 16'h00FF;
    for (int c = 0; c < 9; c++) begin
      case (c)
        0: step(1, 8'h80, 8'h80, 1, 4'd1, 1);
        1: step(1, 8'h80, 8'h80, 0, 4'd2, 1);
        2: step(1, 8'hFF, 8'h01, 1, 4'd3, 1);
        3: step(1, 8'hFF, 8'h01, 0, 4'd4, 1);
        default: step(0, 0, 0, 0, 0, 1);
      endcase
      if (c >= 4 && c < 8) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_product !== exp_p[c-4] || out_tag !== 4'(c-3)) begin
          n_err++; $display("FAIL signed_corner%0d: got v%b %h t%h want v1 %h t%h",
                            c-4, out_valid, out_product, out_tag, exp_p[c-4], 4'(c-3));
        end
      end
      if (c == 8) begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL signed_drain: got valid %b want 0", out_valid); end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 13; c++) begin
      if (c < 8) step(1, B2B_A[c], B2B_B[c], c[0], 4'(c), 1);
      else       step(0, 0, 0, 0, 0, 1);
      if (c < 8) begin
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready c%0d: got %b want 1", c, in_ready); end
      end
      if (c >= 4 && c < 12) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_product !== B2B_P[c-4] || out_tag !== 4'(c-4)) begin
          n_err++; $display("FAIL b2b_result%0d: got v%b %h t%h want v1 %h t%h",
                            c-4, out_valid, out_product, out_tag, B2B_P[c-4], 4'(c-4));
        end
      end
      if (c == 12) begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got valid %b want 0", out_valid); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] exp_p [5];
    exp_p[0] = 16'h0006; exp_p[1] = 16'h0014; exp_p[2] = 16'h002A; exp_p[3] = 16'h0048; exp_p[4] = 16'h006E;
    for (int c = 0; c < 15; c++) begin
      if (c < 4)       step(1, 8'(2*c+2), 8'(2*c+3), 0, 4'(8+c), 1);
      else if (c < 9)  step(1, 8'd10, 8'd11, 0, 4'd12, 0);
      else if (c == 9) step(1, 8'd10, 8'd11, 0, 4'd12, 1);
      else             step(0, 0, 0, 0, 0, 1);
      if (c < 4 || c == 9) begin
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready c%0d: got %b want 1", c, in_ready); end
      end
      if (c >= 4 && c < 9) begin
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_product !== 16'h0006 || out_tag !== 4'd8) begin
          n_err++; $display("FAIL bp_stall c%0d: got rdy%b v%b %h t%h want rdy0 v1 0006 t8",
                            c, in_ready, out_valid, out_product, out_tag);
        end
      end
      if (c >= 9 && c < 14) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_product !== exp_p[c-9] || out_tag !== 4'(c-1)) begin
          n_err++; $display("FAIL bp_release%0d: got v%b %h t%h want v1 %h t%h",
                            c-9, out_valid, out_product, out_tag, exp_p[c-9], 4'(c-1));
        end
      end
      if (c == 14) begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_extra: got valid %b want 0", out_valid); end
      end
    end
  endtask

  task automatic test_reset_midflight;
    for (int c = 0; c < 3; c++) begin
      step(1, 8'(c+1), 8'(c+7), 0, 4'(c), 1);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_accept c%0d: got %b want 1", c, in_ready); end
    end
    step(0, 0, 0, 0, 0, 1);
    rst = 1'b1; #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_rdy_in_reset: got %b want 0", in_ready); end
    step(1, 8'd5, 8'd6, 0, 4'd9, 1);
    rst = 1'b0; #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_product !== 16'h0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL rmid_after: got v%b %h rdy%b want v0 0000 rdy1", out_valid, out_product, in_ready);
    end
    for (int c = 5; c < 11; c++) begin
      step(0, 0, 0, 0, 0, 1);
      n_vec++;
      if (c == 8) begin
        if (out_valid !== 1'b1 || out_product !== 16'h001E || out_tag !== 4'd9) begin
          n_err++; $display("FAIL rmid_first: got v%b %h t%h want v1 001e t9", out_valid, out_product, out_tag);
        end
      end else if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL rmid_stale c%0d: got v%b %h t%h want v0", c, out_valid, out_product, out_tag);
      end
    end
  endtask

  task automatic test_random;
    logic [19:0] q[$];
    logic [19:0] e;
    logic [7:0]  a, b;
    logic        s, v, r;
    int          acc = 0, got = 0, cyc = 0;
    while ((acc < 10000 || got < acc) && cyc < 50000) begin
      v = (acc < 10000) && ($urandom_range(3) != 0);
      r = ($urandom_range(3) != 0);
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      step(v, a, b, s, 4'(acc), r);
      cyc++;
      if (out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rand_unexpected: got %h t%h with nothing pending", out_product, out_tag);
        end else begin
          e = q.pop_front();
          got++;
          if (out_product !== e[15:0] || out_tag !== e[19:16]) begin
            n_err++; $display("FAIL rand_result%0d: got %h t%h want %h t%h", got, out_product, out_tag, e[15:0], e[19:16]);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({4'(acc), ref_mul(a, b, s)});
        acc++;
      end
    end
    n_vec++;
    if (got != 10000) begin
      n_err++; $display("FAIL rand_count: got %0d results in %0d cycles want 10000", got, cyc);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
    test_reset;
    test_unsigned;
    test_signed;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
